// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwarding, operand select and a 2-entry skid buffer toward the ALU.
// Optional macro OPERAND_FWD_EN enables EX/WB forwarding; without it the forwarding ports are ignored.
package alu_operand_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;
endpackage

module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int Width    = 32,
    parameter int RegAddrW = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  alu_op_e             in_op_i,
    input  logic [RegAddrW-1:0] rs1_addr_i,
    input  logic [RegAddrW-1:0] rs2_addr_i,
    input  logic [Width-1:0]    rs1_data_i,
    input  logic [Width-1:0]    rs2_data_i,
    input  logic [Width-1:0]    pc_i,
    input  logic [Width-1:0]    imm_i,
    input  logic                a_sel_i,
    input  logic                b_sel_i,
    input  logic                fwd_ex_valid_i,
    input  logic [RegAddrW-1:0] fwd_ex_rd_i,
    input  logic [Width-1:0]    fwd_ex_data_i,
    input  logic                fwd_wb_valid_i,
    input  logic [RegAddrW-1:0] fwd_wb_rd_i,
    input  logic [Width-1:0]    fwd_wb_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output alu_op_e             op_o,
    output logic [Width-1:0]    a_o,
    output logic [Width-1:0]    b_o
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;

    state_e         r_state, w_state_nxt;
    logic           r_out_valid, r_in_ready;
    alu_op_e        r_main_op, r_skid_op;
    logic [Width-1:0] r_main_a, r_main_b, r_skid_a, r_skid_b;
    logic [Width-1:0] w_rs1, w_rs2, w_a, w_b;
    logic           w_in_xfer, w_out_xfer;
    logic           w_ld_main_in, w_ld_main_skid, w_ld_skid;

`ifdef OPERAND_FWD_EN
    // x0 is hardwired, so a producer "writing" it must never be forwarded.
    always_comb begin
        w_rs1 = rs1_data_i;
        if (rs1_addr_i != '0 && fwd_ex_valid_i && fwd_ex_rd_i == rs1_addr_i)
            w_rs1 = fwd_ex_data_i;
        else if (rs1_addr_i != '0 && fwd_wb_valid_i && fwd_wb_rd_i == rs1_addr_i)
            w_rs1 = fwd_wb_data_i;

        w_rs2 = rs2_data_i;
        if (rs2_addr_i != '0 && fwd_ex_valid_i && fwd_ex_rd_i == rs2_addr_i)
            w_rs2 = fwd_ex_data_i;
        else if (rs2_addr_i != '0 && fwd_wb_valid_i && fwd_wb_rd_i == rs2_addr_i)
            w_rs2 = fwd_wb_data_i;
    end
`else
    // Hazards are resolved by stalling upstream; forwarding inputs are intentionally unused.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{rs1_addr_i, rs2_addr_i, fwd_ex_valid_i, fwd_ex_rd_i, fwd_ex_data_i,
                            fwd_wb_valid_i, fwd_wb_rd_i, fwd_wb_data_i};
    assign w_rs1 = rs1_data_i;
    assign w_rs2 = rs2_data_i;
`endif

    assign w_a        = a_sel_i ? pc_i  : w_rs1;
    assign w_b        = b_sel_i ? imm_i : w_rs2;
    assign w_in_xfer  = in_valid_i & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_ld_main_in = 1'b1;
                        w_state_nxt  = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_in_xfer) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = ST_SKID;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = ST_FULL;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags are flopped from the next state so neither side sees a combinational path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_SKID);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_main_op <= ALU_ADD;
            r_main_a  <= '0;
            r_main_b  <= '0;
            r_skid_op <= ALU_ADD;
            r_skid_a  <= '0;
            r_skid_b  <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main_op <= in_op_i;
                r_main_a  <= w_a;
                r_main_b  <= w_b;
            end else if (w_ld_main_skid) begin
                r_main_op <= r_skid_op;
                r_main_a  <= r_skid_a;
                r_main_b  <= r_skid_b;
            end
            if (w_ld_skid) begin
                r_skid_op <= in_op_i;
                r_skid_a  <= w_a;
                r_skid_b  <= w_b;
            end
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign op_o        = r_main_op;
    assign a_o         = r_main_a;
    assign b_o         = r_main_b;

endmodule
